// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state codes,
// default operand width and a counter-width helper.
package serial_subtractor_pkg;

  localparam int SUB_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Bits needed to count 0..w-1; never less than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// Combinational full-subtractor cell built from two half subtractors
// and an OR gate that merges their borrows.

// Half subtractor: d = x - y, bout set when y exceeds x.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bout
);
  assign d    = x ^ y;
  assign bout = ~x & y;
endmodule

// Full subtractor: d = x - y - bin with borrow out.
module fullsubtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;

  half_subtractor u_hs0 (.x(x),  .y(y),   .d(d1), .bout(b1));
  half_subtractor u_hs1 (.x(d1), .y(bin), .d(d),  .bout(b2));

  assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per
// clock, with a start/ready/done handshake and a registered borrow chain.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int W = SUB_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  localparam int CW = cnt_width(W);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          bq_q, bq_d;
  logic          bout_q, bout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic cell_d, cell_bn;
  logic last;
  logic load;

  fullsubtractor_cell u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (bq_q),
    .d    (cell_d),
    .bout (cell_bn)
  );

  assign last = (cnt_q == CW'(W - 1));

  // Next-state logic: accept in IDLE/DONE, shift W times, publish on the last bit.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bq_d    = bq_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        load = start;
      end
      ST_SHIFT: begin
        a_d   = {1'b0, a_q[W-1:1]};
        b_d   = {1'b0, b_q[W-1:1]};
        res_d = {cell_d, res_q[W-1:1]};
        bq_d  = cell_bn;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = ST_DONE;
          diff_d  = {cell_d, res_q[W-1:1]};
          bout_d  = cell_bn;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        load    = start;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Operand capture shared by IDLE and the back-to-back path out of DONE.
    if (load) begin
      state_d = ST_SHIFT;
      a_d     = a;
      b_d     = b;
      res_d   = '0;
      bq_d    = 1'b0;
      cnt_d   = '0;
    end
  end

  // State, datapath and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bq_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bq_q    <= bq_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready      = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy       = (state_q == ST_SHIFT);
  assign done       = (state_q == ST_DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit instance for directed,
// random, handshake and reset cases, and a 4-bit instance swept over all pairs.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  logic       start8, ready8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;
  logic       start4, ready4, busy4, done4, bo4;
  logic [3:0] a4, b4, diff4;

  int errors;
  int checks;

  serial_subtractor #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .ready(ready4), .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for done on the selected instance, counting busy cycles.
  task automatic wait_done(input bit wide, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!(wide ? done8 : done4) && lat < 40) begin
      if (wide ? busy8 : busy4) bcnt++;
      tick();
      lat++;
    end
  endtask

  // One transaction against the reference: (a - b) mod 2^W, borrow iff a < b,
  // done W+1 edges after the capture edge inclusive, busy for W cycles.
  task automatic check_op(input bit wide, input int av, input int bv, input string tag);
    int w, mask, k, lat, bcnt;
    int exp_d, exp_b;
    w     = wide ? 8 : 4;
    mask  = (1 << w) - 1;
    exp_d = (av - bv) & mask;
    exp_b = (av < bv) ? 1 : 0;
    k = 0;
    while (!(wide ? ready8 : ready4) && k < 40) begin
      tick();
      k++;
    end
    if (wide) begin start8 = 1'b1; a8 = 8'(av); b8 = 8'(bv); end
    else      begin start4 = 1'b1; a4 = 4'(av); b4 = 4'(bv); end
    tick();
    start8 = 1'b0;
    start4 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    a4 = 4'($urandom);
    b4 = 4'($urandom);
    wait_done(wide, lat, bcnt);
    chk({tag, " latency"}, lat + 1, w + 1);
    chk({tag, " busy_cycles"}, bcnt, w);
    chk({tag, " diff"}, wide ? 32'(diff8) : 32'(diff4), exp_d);
    chk({tag, " borrow"}, wide ? 32'(bo8) : 32'(bo4), exp_b);
  endtask

  initial begin
    int lat, bcnt, pulses;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;

    #3;
    chk("rst ready", ready8, 1);
    chk("rst busy", busy8, 0);
    chk("rst done", done8, 0);
    chk("rst diff", diff8, 0);
    chk("rst borrow", bo8, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Directed cases
    check_op(1'b1, 13, 5, "basic");
    check_op(1'b1, 5, 13, "borrow");
    check_op(1'b1, 0, 255, "zero_minus_max");
    check_op(1'b1, 8'hA5, 8'hA5, "equal");
    check_op(1'b1, 255, 0, "max_minus_zero");

    // Idle hold: outputs keep last result while no start arrives
    repeat (3) tick();
    chk("idle diff hold", diff8, 255);
    chk("idle borrow hold", bo8, 0);
    chk("idle ready", ready8, 1);
    chk("idle done", done8, 0);

    // Random operands
    for (int i = 0; i < 24; i++) begin
      check_op(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "random");
    end

    // Handshake: start held through SHIFT (ignored) and through DONE (back-to-back)
    start8 = 1'b1; a8 = 8'd13; b8 = 8'd5;
    tick();
    a8 = 8'd1; b8 = 8'd2;
    wait_done(1'b1, lat, bcnt);
    chk("hs first latency", lat + 1, 9);
    chk("hs first diff", diff8, 8);
    chk("hs first borrow", bo8, 0);
    tick();
    start8 = 1'b0;
    a8 = 8'd77; b8 = 8'd11;
    chk("hs b2b busy", busy8, 1);
    wait_done(1'b1, lat, bcnt);
    chk("hs second latency", lat + 1, 9);
    chk("hs second diff", diff8, 255);
    chk("hs second borrow", bo8, 1);
    tick();

    // Asynchronous reset in the third SHIFT cycle
    start8 = 1'b1; a8 = 8'd13; b8 = 8'd5;
    tick();
    start8 = 1'b0;
    repeat (2) tick();
    chk("pre-abort busy", busy8, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort ready", ready8, 1);
    chk("abort busy", busy8, 0);
    chk("abort done", done8, 0);
    chk("abort diff", diff8, 0);
    chk("abort borrow", bo8, 0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) pulses++;
      tick();
    end
    chk("abort no done", pulses, 0);
    check_op(1'b1, 200, 100, "post_abort");

    // Exhaustive 4-bit sweep
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        check_op(1'b0, x, y, "w4");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
